// File: rtl/ulpb_tx_msg_seq_pkg.sv
// ---------------------------------------------------------------------------
// ulpb_tx_msg_seq_pkg
//   Shared definitions for the ULPB TX message sequencer:
//   - bus widths for destination address and data words
//   - FSM state encoding of the sequencer
//   - safe_clog2 helper: pointer/counter width that never collapses to 0 bits
// ---------------------------------------------------------------------------
package ulpb_tx_msg_seq_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_FILL     = 3'd0,
        ST_REQ      = 3'd1,
        ST_ACK_HI   = 3'd2,
        ST_ACK_LO   = 3'd3,
        ST_RESP     = 3'd4,
        ST_RESP_CLR = 3'd5
    } seq_state_e;

    // Width needed to index/count 'v' values, at least 1 bit.
    function automatic int safe_clog2(input int v);
        if (v <= 1) begin
            return 1;
        end else begin
            return $clog2(v);
        end
    endfunction

endpackage

// File: rtl/ulpb_tx_msg_seq_if.sv
// ---------------------------------------------------------------------------
// ulpb_tx_msg_seq_if
//   TX port of a ulpb_node32 as seen from the local side.
//   master: the sequencer (drives address/data/request/pending/priority and
//           the response acknowledge; observes ack/success/fail)
//   slave : the node (the opposite directions)
//   tx_prio carries the node's PRIORITY input.
// ---------------------------------------------------------------------------
interface ulpb_tx_msg_seq_if;
    import ulpb_tx_msg_seq_pkg::*;

    logic [ADDR_WIDTH-1:0] tx_addr;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_req;
    logic                  tx_pend;
    logic                  tx_prio;
    logic                  tx_ack;
    logic                  tx_succ;
    logic                  tx_fail;
    logic                  tx_resp_ack;

    modport master (
        output tx_addr, tx_data, tx_req, tx_pend, tx_prio, tx_resp_ack,
        input  tx_ack, tx_succ, tx_fail
    );

    modport slave (
        input  tx_addr, tx_data, tx_req, tx_pend, tx_prio, tx_resp_ack,
        output tx_ack, tx_succ, tx_fail
    );
endinterface

// File: rtl/ulpb_tx_msg_seq_buf.sv
// ---------------------------------------------------------------------------
// ulpb_tx_msg_seq_buf
//   DEPTH x WIDTH message buffer, one write port and one read port.
//   Ports:
//     clk_i, rst_ni  clock, synchronous active-low reset
//     clr_i          drop the whole message (write pointer and count to 0)
//     wr_i, wdata_i  push one word at wr_ptr
//     rd_clr_i       restart reading at word 0 (new send or replay)
//     rd_inc_i       advance to the next word
//     rdata_o        word at rd_ptr (combinational read)
//     cnt_o          number of words held
//     rd_ptr_o       current read index
//   Pointers never wrap inside one message: the controller closes the message
//   on the push that fills the buffer.
// ---------------------------------------------------------------------------
module ulpb_tx_msg_seq_buf
    import ulpb_tx_msg_seq_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = DATA_WIDTH,
    localparam int PW    = safe_clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_clr_i,
    input  logic             rd_inc_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    cnt_o,
    output logic [PW-1:0]    rd_ptr_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;

    // Write pointer, count and read pointer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (clr_i) begin
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else if (wr_i) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                cnt_q    <= cnt_q + CW'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
                cnt_q    <= cnt_q;
            end
            if (rd_clr_i) begin
                rd_ptr_q <= '0;
            end else if (rd_inc_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
        end
    end

    // Storage array; contents survive a replay.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign rdata_o  = mem_q[rd_ptr_q];
    assign cnt_o    = cnt_q;
    assign rd_ptr_o = rd_ptr_q;

endmodule

// File: rtl/ulpb_tx_msg_seq.sv
// ---------------------------------------------------------------------------
// ulpb_tx_msg_seq
//   Local TX sequencer in front of a ulpb_node32 TX port. A controller pushes
//   a 1..DEPTH word message; the block then offers it word by word on the
//   node's 4-phase REQ/ACK handshake, closes the SUCC/FAIL response with
//   RESP_ACK and replays the whole message on failure up to MAX_RETRY times.
//   Ports:
//     clk_i, rst_ni      clock, synchronous active-low reset
//     msg_addr_i/prio_i  destination and priority, taken from the first word
//     msg_data_i         word to push
//     msg_wr_i           push strobe, honoured only while msg_rdy_o=1
//     msg_last_i         this word closes the message
//     msg_rdy_o          buffer accepting words
//     msg_done_o         1-cycle pulse: message delivered
//     msg_err_o          1-cycle pulse: delivery failed, retries exhausted
//     retry_cnt_o        resends used by the current/last message
//     tx                 node TX port (master side)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module ulpb_tx_msg_seq
    import ulpb_tx_msg_seq_pkg::*;
#(
    parameter  int DEPTH     = 4,
    parameter  int MAX_RETRY = 3,
    localparam int PW        = safe_clog2(DEPTH),
    localparam int CW        = PW + 1,
    localparam int RW        = safe_clog2(MAX_RETRY + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [ADDR_WIDTH-1:0]  msg_addr_i,
    input  logic                   msg_prio_i,
    input  logic [DATA_WIDTH-1:0]  msg_data_i,
    input  logic                   msg_wr_i,
    input  logic                   msg_last_i,
    output logic                   msg_rdy_o,
    output logic                   msg_done_o,
    output logic                   msg_err_o,
    output logic [RW-1:0]          retry_cnt_o,
    ulpb_tx_msg_seq_if.master      tx
);

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  prio_q, prio_d;
    logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_req_q, tx_req_d;
    logic                  tx_pend_q, tx_pend_d;
    logic                  tx_prio_q, tx_prio_d;
    logic                  resp_ack_q, resp_ack_d;
    logic                  fail_q, fail_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic                  rdy_q, rdy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  wr_en_s;
    logic                  clr_s;
    logic                  rd_clr_s;
    logic                  rd_inc_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic [CW-1:0]         cnt_s;
    logic [PW-1:0]         rd_ptr_s;
    logic                  pend_s;

    ulpb_tx_msg_seq_buf #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr_s),
        .wr_i     (wr_en_s),
        .wdata_i  (msg_data_i),
        .rd_clr_i (rd_clr_s),
        .rd_inc_i (rd_inc_s),
        .rdata_o  (rdata_s),
        .cnt_o    (cnt_s),
        .rd_ptr_o (rd_ptr_s)
    );

    // More words follow the one at rd_ptr.
    assign pend_s = ({1'b0, rd_ptr_s} != (cnt_s - CW'(1)));

    // Next-state, handshake and buffer control.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        prio_d     = prio_q;
        tx_addr_d  = tx_addr_q;
        tx_data_d  = tx_data_q;
        tx_req_d   = tx_req_q;
        tx_pend_d  = tx_pend_q;
        tx_prio_d  = tx_prio_q;
        resp_ack_d = resp_ack_q;
        fail_d     = fail_q;
        retry_d    = retry_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wr_en_s    = 1'b0;
        clr_s      = 1'b0;
        rd_clr_s   = 1'b0;
        rd_inc_s   = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (msg_wr_i && rdy_q) begin
                    wr_en_s = 1'b1;
                    if (cnt_s == CW'(0)) begin
                        addr_d = msg_addr_i;
                        prio_d = msg_prio_i;
                    end else begin
                        addr_d = addr_q;
                        prio_d = prio_q;
                    end
                    // The push that fills the buffer always closes the message.
                    if (msg_last_i || (cnt_s == CW'(DEPTH - 1))) begin
                        rd_clr_s = 1'b1;
                        retry_d  = '0;
                        state_d  = ST_REQ;
                    end else begin
                        state_d  = ST_FILL;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end

            ST_REQ: begin
                if (tx.tx_fail) begin
                    tx_req_d   = 1'b0;
                    resp_ack_d = 1'b1;
                    fail_d     = 1'b1;
                    state_d    = ST_RESP_CLR;
                end else begin
                    tx_addr_d = addr_q;
                    tx_prio_d = prio_q;
                    tx_data_d = rdata_s;
                    tx_pend_d = pend_s;
                    tx_req_d  = 1'b1;
                    state_d   = ST_ACK_HI;
                end
            end

            ST_ACK_HI: begin
                // A fail beats a simultaneous ack: the word is abandoned.
                if (tx.tx_fail) begin
                    tx_req_d   = 1'b0;
                    resp_ack_d = 1'b1;
                    fail_d     = 1'b1;
                    state_d    = ST_RESP_CLR;
                end else if (tx.tx_ack) begin
                    tx_req_d = 1'b0;
                    state_d  = ST_ACK_LO;
                end else begin
                    state_d  = ST_ACK_HI;
                end
            end

            ST_ACK_LO: begin
                if (tx.tx_fail) begin
                    tx_req_d   = 1'b0;
                    resp_ack_d = 1'b1;
                    fail_d     = 1'b1;
                    state_d    = ST_RESP_CLR;
                end else if (!tx.tx_ack) begin
                    if (tx_pend_q) begin
                        rd_inc_s = 1'b1;
                        state_d  = ST_REQ;
                    end else begin
                        state_d  = ST_RESP;
                    end
                end else begin
                    state_d = ST_ACK_LO;
                end
            end

            ST_RESP: begin
                // SUCC together with FAIL counts as a failure.
                if (tx.tx_succ || tx.tx_fail) begin
                    resp_ack_d = 1'b1;
                    fail_d     = tx.tx_fail;
                    state_d    = ST_RESP_CLR;
                end else begin
                    state_d    = ST_RESP;
                end
            end

            ST_RESP_CLR: begin
                if (!tx.tx_succ && !tx.tx_fail) begin
                    resp_ack_d = 1'b0;
                    if (!fail_q) begin
                        done_d  = 1'b1;
                        clr_s   = 1'b1;
                        state_d = ST_FILL;
                    end else if (int'(retry_q) < MAX_RETRY) begin
                        retry_d  = retry_q + RW'(1);
                        rd_clr_s = 1'b1;
                        state_d  = ST_REQ;
                    end else begin
                        err_d   = 1'b1;
                        clr_s   = 1'b1;
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_RESP_CLR;
                end
            end

            default: begin
                tx_req_d   = 1'b0;
                resp_ack_d = 1'b0;
                clr_s      = 1'b1;
                state_d    = ST_FILL;
            end
        endcase

        // A full buffer always leaves FILL, so being in FILL implies room.
        rdy_d = (state_d == ST_FILL);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_FILL;
            addr_q     <= '0;
            prio_q     <= 1'b0;
            tx_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_req_q   <= 1'b0;
            tx_pend_q  <= 1'b0;
            tx_prio_q  <= 1'b0;
            resp_ack_q <= 1'b0;
            fail_q     <= 1'b0;
            retry_q    <= '0;
            rdy_q      <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            prio_q     <= prio_d;
            tx_addr_q  <= tx_addr_d;
            tx_data_q  <= tx_data_d;
            tx_req_q   <= tx_req_d;
            tx_pend_q  <= tx_pend_d;
            tx_prio_q  <= tx_prio_d;
            resp_ack_q <= resp_ack_d;
            fail_q     <= fail_d;
            retry_q    <= retry_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign msg_rdy_o      = rdy_q;
    assign msg_done_o     = done_q;
    assign msg_err_o      = err_q;
    assign retry_cnt_o    = retry_q;
    assign tx.tx_addr     = tx_addr_q;
    assign tx.tx_data     = tx_data_q;
    assign tx.tx_req      = tx_req_q;
    assign tx.tx_pend     = tx_pend_q;
    assign tx.tx_prio     = tx_prio_q;
    assign tx.tx_resp_ack = resp_ack_q;

endmodule
